// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 raster constants for the VGA timing slice.
// Visible, front-porch, sync and back-porch widths for both axes, their
// totals, the default pixel prescale and sync polarity, and the counter width
// used for the pixel_x / pixel_y buses.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixels.
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // Vertical timing, in lines.
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // 100 MHz system clock / 4 = 25 MHz pixel clock.
    localparam int VGA_CLK_DIV   = 4;

    // Classic 640x480 uses negative-going sync pulses.
    localparam bit VGA_SYNC_POL  = 1'b0;

    // Wide enough for H_TOTAL-1 (799) and V_TOTAL-1 (524).
    localparam int VGA_CNT_W     = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each step
// and wraps to 0. All decode outputs are taken from the next-state value so
// the parent can register them alongside the counter on the same edge.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high; counter parks at TOTAL-1
//   step       in   advance the counter by one on this edge
//   cnt_next   out  counter value after this edge
//   wrap       out  this edge steps from TOTAL-1 back to 0
//   in_sync    out  cnt_next lies inside the sync pulse window
//   in_visible out  cnt_next lies inside the visible region
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int CNT_W   = 10,
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] cnt_next,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_visible
);

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] VIS_LIMIT  = CNT_W'(VISIBLE);

    logic [CNT_W-1:0] cnt;

    // Next-state and decode. Parking at TOTAL-1 out of reset means the very
    // first step lands on 0 and reports a wrap.
    always_comb begin
        wrap     = step && (cnt == CNT_LAST);
        cnt_next = cnt;
        if (step) begin
            if (cnt == CNT_LAST) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
        in_sync    = (cnt_next >= SYNC_FIRST) && (cnt_next <= SYNC_LAST);
        in_visible = (cnt_next < VIS_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= CNT_LAST;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/vga_sync_timing.sv
// ---------------------------------------------------------------------------
// vga_sync_timing
// 640x480@60 VGA raster timing generator. A prescaler turns the system clock
// into a pixel rate; two axis counters walk the raster; every output is a
// register loaded from next-state counter values so sync, blanking, strobes
// and coordinates always describe the same pixel.
//
// Ports
//   clk         in   system clock, single domain
//   reset       in   asynchronous, active-high (from the reset synchronizer)
//   enable      in   1 = run, 0 = freeze all state and suppress strobes
//   pixel_tick  out  one-clk pulse after each counter advance
//   pixel_x     out  horizontal position 0..H_TOTAL-1
//   pixel_y     out  vertical position 0..V_TOTAL-1
//   video_on    out  inside the visible window
//   hsync       out  horizontal sync, SYNC_POL when asserted
//   vsync       out  vertical sync, SYNC_POL when asserted
//   line_start  out  one-clk pulse when pixel_x becomes 0
//   frame_start out  one-clk pulse when (pixel_x, pixel_y) becomes (0, 0)
// ---------------------------------------------------------------------------
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter bit SYNC_POL  = VGA_SYNC_POL,
    parameter int CNT_W     = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // A one-bit prescaler is kept even for CLK_DIV=1; it simply stays at 0
    // and every enabled edge becomes an advance edge.
    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [PRESC_W-1:0] presc;
    logic               advance;

    logic [CNT_W-1:0]   h_next;
    logic               h_wrap;
    logic               h_in_sync;
    logic               h_in_visible;

    logic [CNT_W-1:0]   v_next;
    logic               v_wrap;
    logic               v_in_sync;
    logic               v_in_visible;

    assign advance = enable && (presc == PRESC_LAST);

    // Prescaler only moves on enabled edges, so a pause resumes mid-count
    // and the pixel period across the pause is unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (enable) begin
            if (advance) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    vga_axis_counter #(
        .CNT_W   (CNT_W),
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_counter (
        .clk        (clk),
        .reset      (reset),
        .step       (advance),
        .cnt_next   (h_next),
        .wrap       (h_wrap),
        .in_sync    (h_in_sync),
        .in_visible (h_in_visible)
    );

    // The vertical axis steps only on the edge where the line wraps, so both
    // axes wrap together at the end of a frame.
    vga_axis_counter #(
        .CNT_W   (CNT_W),
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_counter (
        .clk        (clk),
        .reset      (reset),
        .step       (h_wrap),
        .cnt_next   (v_next),
        .wrap       (v_wrap),
        .in_sync    (v_in_sync),
        .in_visible (v_in_visible)
    );

    // Output registers. Everything is loaded from next-state counter values
    // on the same edge, so there is no skew between coordinates and flags.
    // While disabled the level outputs hold and the strobes are cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= H_LAST;
            pixel_y     <= V_LAST;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else if (enable) begin
            pixel_tick  <= advance;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            pixel_x     <= h_next;
            pixel_y     <= v_next;
            video_on    <= h_in_visible && v_in_visible;
            hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
        end else begin
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_timing
// Two instances share clock, reset and enable: u_dflt uses the standard
// 640x480 timing with CLK_DIV=4, active-low sync; u_small uses a reduced
// 30x19 raster with CLK_DIV=3 and active-high sync so whole frames and the
// vertical sync lines can be exercised in a short run. The reference model
// derives the raster position from the number of enabled edges since reset.
// ---------------------------------------------------------------------------
module tb_vga_sync_timing;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;

    logic       d_tick, d_ls, d_fs, d_von, d_hs, d_vs;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_ls, s_fs, s_von, s_hs, s_vs;
    logic [9:0] s_x, s_y;

    logic [25:0] obs_d;
    logic [25:0] obs_s;
    assign obs_d = {d_tick, d_ls, d_fs, d_von, d_hs, d_vs, d_x, d_y};
    assign obs_s = {s_tick, s_ls, s_fs, s_von, s_hs, s_vs, s_x, s_y};

    int tests_run = 0;
    int fails     = 0;
    int k         = 0;
    bit last_en   = 1'b0;

    always #5 clk = ~clk;

    vga_sync_timing u_dflt (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pixel_tick  (d_tick),
        .pixel_x     (d_x),
        .pixel_y     (d_y),
        .video_on    (d_von),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .line_start  (d_ls),
        .frame_start (d_fs)
    );

    vga_sync_timing #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .CLK_DIV   (3),  .SYNC_POL (1'b1), .CNT_W (10)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pixel_tick  (s_tick),
        .pixel_x     (s_x),
        .pixel_y     (s_y),
        .video_on    (s_von),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    // Reference: after kk enabled edges there have been kk/div advances; the
    // first advance shows pixel 0, so the raster index is (advances-1).
    function automatic logic [25:0] ref_pos(input int hv, input int hf, input int hsw, input int hb,
                                            input int vv, input int vf, input int vsw, input int vb,
                                            input int div, input bit pol, input int kk, input bit en);
        int ht, vt, a, x, y;
        logic adv, von, hs, vs;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        a  = kk / div;
        if (a == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            x = (a - 1) % ht;
            y = ((a - 1) / ht) % vt;
        end
        adv = en && (kk > 0) && (kk % div == 0);
        von = (x < hv) && (y < vv);
        hs  = (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol;
        vs  = (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol;
        return {adv, adv && (x == 0), adv && (x == 0) && (y == 0), von, hs, vs, 10'(x), 10'(y)};
    endfunction

    function automatic logic [25:0] exp_d();
        return ref_pos(640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, k, last_en);
    endfunction

    function automatic logic [25:0] exp_s();
        return ref_pos(16, 4, 6, 4, 12, 2, 2, 3, 3, 1'b1, k, last_en);
    endfunction

    // One clock edge, with the model updated from the inputs at that edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            k = 0;
            last_en = 1'b0;
        end else if (enable) begin
            k++;
            last_en = 1'b1;
        end else begin
            last_en = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        k = 0;
        last_en = 1'b0;
        #1;
        tests_run++;
        if (obs_d !== {6'b000011, 10'd799, 10'd524}) begin
            fails++;
            $display("[TB] FAIL reset_value_dflt got %h expected %h", obs_d, {6'b000011, 10'd799, 10'd524});
        end
        tests_run++;
        if (obs_s !== exp_s()) begin
            fails++;
            $display("[TB] FAIL reset_value_small got %h expected %h", obs_s, exp_s());
        end
        repeat (3) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL reset_hold got %h/%h expected %h/%h", obs_d, obs_s, exp_d(), exp_s());
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_pixel();
        int edges;
        bit found;
        edges = 0;
        found = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 8 && !found; i++) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL first_pixel_run k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (d_tick) begin
                found = 1'b1;
                edges = i;
            end
        end
        tests_run++;
        if (edges != 4) begin
            fails++;
            $display("[TB] FAIL first_tick_edge got %0d expected 4", edges);
        end
        tests_run++;
        if (obs_d !== {6'b111111, 20'd0}) begin
            fails++;
            $display("[TB] FAIL first_pixel_state got %h expected %h", obs_d, {6'b111111, 20'd0});
        end
    endtask

    task automatic test_line0();
        int von_fall, hs_fall, hs_rise;
        bit done;
        logic pv, ph;
        von_fall = -1;
        hs_fall = -1;
        hs_rise = -1;
        done = 1'b0;
        pv = d_von;
        ph = d_hs;
        for (int i = 0; i < 3300 && !done; i++) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL line0_run k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (d_tick) begin
                if (pv && !d_von && von_fall < 0) von_fall = int'(d_x);
                if (ph && !d_hs && hs_fall < 0) hs_fall = int'(d_x);
                if (!ph && d_hs && hs_rise < 0) hs_rise = int'(d_x);
                pv = d_von;
                ph = d_hs;
                if (d_x == 10'd799) done = 1'b1;
            end
        end
        tests_run++;
        if (!done || d_y !== 10'd0) begin
            fails++;
            $display("[TB] FAIL line0_end got done=%0d y=%0d expected done=1 y=0", done, d_y);
        end
        tests_run++;
        if (von_fall != 640) begin
            fails++;
            $display("[TB] FAIL video_on_fall_x got %0d expected 640", von_fall);
        end
        tests_run++;
        if (hs_fall != 656) begin
            fails++;
            $display("[TB] FAIL hsync_assert_x got %0d expected 656", hs_fall);
        end
        tests_run++;
        if (hs_rise != 752) begin
            fails++;
            $display("[TB] FAIL hsync_release_x got %0d expected 752", hs_rise);
        end
    endtask

    task automatic test_line_wrap();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL wrap_run k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (d_tick) found = 1'b1;
        end
        tests_run++;
        if ({d_x, d_y, d_ls, d_fs} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL line_wrap got x=%0d y=%0d ls=%b fs=%b expected x=0 y=1 ls=1 fs=0", d_x, d_y, d_ls, d_fs);
        end
    endtask

    task automatic test_frame();
        int t, t1, t2, ls_cnt;
        logic [31:0] vs_mask;
        t = 0;
        t1 = -1;
        t2 = -1;
        ls_cnt = 0;
        vs_mask = '0;
        for (int i = 0; i < 4000 && t2 < 0; i++) begin
            tick();
            t++;
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL frame_run k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (s_fs) begin
                if (t1 < 0) t1 = t;
                else if (t2 < 0) t2 = t;
            end
            if (t1 >= 0 && t != t1 && s_ls) ls_cnt++;
            if (t1 >= 0 && s_tick && s_vs) vs_mask[s_y[4:0]] = 1'b1;
        end
        tests_run++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != 1710) begin
            fails++;
            $display("[TB] FAIL frame_spacing got %0d expected 1710", t2 - t1);
        end
        tests_run++;
        if (ls_cnt != 19) begin
            fails++;
            $display("[TB] FAIL lines_per_frame got %0d expected 19", ls_cnt);
        end
        tests_run++;
        if (vs_mask !== 32'h0000_C000) begin
            fails++;
            $display("[TB] FAIL vsync_lines got %h expected 0000c000", vs_mask);
        end
    endtask

    task automatic test_enable_freeze();
        bit found;
        int n;
        found = 1'b0;
        for (int i = 0; i < 3300 && !found; i++) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL freeze_seek k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (d_tick && d_x == 10'd300) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL freeze_reach_x300 got x=%0d expected 300", d_x);
        end
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s() || d_x !== 10'd300 ||
                {d_tick, d_ls, d_fs, s_tick, s_ls, s_fs} !== 6'b0) begin
                fails++;
                $display("[TB] FAIL frozen got %h/%h expected %h/%h", obs_d, obs_s, exp_d(), exp_s());
            end
        end
        enable = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            n++;
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL resume_run got %h/%h expected %h/%h", obs_d, obs_s, exp_d(), exp_s());
            end
            if (d_tick) found = 1'b1;
        end
        tests_run++;
        if (2 + n != 4 || d_x !== 10'd301) begin
            fails++;
            $display("[TB] FAIL resume_tick got spacing=%0d x=%0d expected spacing=4 x=301", 2 + n, d_x);
        end
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL random_enable k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3300 && !found; i++) begin
            tick();
            tests_run++;
            if (obs_d !== exp_d() || obs_s !== exp_s()) begin
                fails++;
                $display("[TB] FAIL async_seek k=%0d got %h/%h expected %h/%h", k, obs_d, obs_s, exp_d(), exp_s());
            end
            if (d_tick && d_x == 10'd700) found = 1'b1;
        end
        #2;
        reset = 1'b1;
        k = 0;
        last_en = 1'b0;
        #1;
        tests_run++;
        if (!found || obs_d !== {6'b000011, 10'd799, 10'd524}) begin
            fails++;
            $display("[TB] FAIL async_reset_dflt got %h expected %h", obs_d, {6'b000011, 10'd799, 10'd524});
        end
        tests_run++;
        if (obs_s !== exp_s()) begin
            fails++;
            $display("[TB] FAIL async_reset_small got %h expected %h", obs_s, exp_s());
        end
        test_reset();
        test_first_pixel();
    endtask

    initial begin
        #2;
        test_reset();
        test_first_pixel();
        test_line0();
        test_line_wrap();
        test_frame();
        test_enable_freeze();
        test_random_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
